// File: rtl/exc_chk_pkg.sv
// Shared types for the 16-bit exception-check handshake: AEXC codes, requester states,
// and a bfloat16 classifier used by checker-side models.
package exc_chk_pkg;

  typedef enum logic [2:0] {
    EXC_NORMAL = 3'b000,
    EXC_INF    = 3'b011,
    EXC_NAN    = 3'b100,
    EXC_ZERO   = 3'b111
  } exc_code_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } req_state_e;

  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  // Sign is ignored: both +0 and -0 classify as zero.
  function automatic exc_code_e bf16_exc(input logic [15:0] v);
    if (v[14:7] == EXP_ALL_ONES) return (v[6:0] == 7'd0) ? EXC_INF : EXC_NAN;
    else if (v[14:0] == 15'd0)   return EXC_ZERO;
    else                         return EXC_NORMAL;
  endfunction

endpackage

// File: rtl/exc_result_reg.sv
// One-entry valid/ready holding register for a captured operand, its AEXC code and
// the watchdog flag. A load always wins over a same-cycle drain.
module exc_result_reg
  import exc_chk_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        load,
  input  logic [15:0] load_data,
  input  exc_code_e   load_exc,
  input  logic        load_timeout,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output exc_code_e   out_exc,
  output logic        out_timeout
);

  // NOTE: reset is sampled on the clock edge; all state uses non-blocking assignment.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      out_valid   <= 1'b0;
      out_data    <= 16'd0;
      out_exc     <= EXC_NORMAL;
      out_timeout <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_data    <= load_data;
      out_exc     <= load_exc;
      out_timeout <= load_timeout;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/exc_check_requester.sv
// Initiator side of the exception-check handshake: IDLE -> REQ -> GAP requester FSM.
// Optional REQ watchdog is enabled by defining EXC_REQ_TIMEOUT_EN.
module exc_check_requester
  import exc_chk_pkg::*;
#(
  parameter int GAP_CYCLES = 1
`ifdef EXC_REQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic [15:0] Data,
  output logic        Data_valid,
  input  logic        ACK,
  input  logic [2:0]  AEXC,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_exc,
  output logic        out_timeout,
  output logic        stray_ack
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  req_state_e       state_q, state_d;
  logic [15:0]      data_q, data_d;
  logic             dv_q, dv_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             stray_q, stray_d;
  logic             res_load, res_timeout;
  exc_code_e        res_exc;
  exc_code_e        out_exc_e;
  logic             to_hit;

`ifdef EXC_REQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q;

  // Counts REQ cycles from entry; zero on the first REQ cycle.
  always_ff @(posedge CLK) begin
    if (!RSTN || state_q != REQ) to_q <= '0;
    else                         to_q <= to_q + 1'b1;
  end
  assign to_hit = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  // A request is only accepted when no result can be left stranded in the output register.
  assign in_ready   = (state_q == IDLE) && (!out_valid || out_ready);
  assign Data       = data_q;
  assign Data_valid = dv_q;
  assign stray_ack  = stray_q;
  assign out_exc    = out_exc_e;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    dv_d        = dv_q;
    gap_d       = gap_q;
    stray_d     = stray_q;
    res_load    = 1'b0;
    res_timeout = 1'b0;
    res_exc     = ACK ? exc_code_e'(AEXC) : EXC_NORMAL;
    case (state_q)
      IDLE: begin
        if (ACK) stray_d = 1'b1;
        if (in_valid && in_ready) begin
          data_d  = in_data;
          dv_d    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // ACK on the watchdog limit cycle takes priority and is a normal result.
        if (ACK || to_hit) begin
          res_load    = 1'b1;
          res_timeout = !ACK;
          dv_d        = 1'b0;
          gap_d       = GAP_W'(GAP_CYCLES - 1);
          state_d     = GAP;
        end
      end
      GAP: begin
        if (ACK) stray_d = 1'b1;
        dv_d = 1'b0;
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      data_q  <= 16'd0;
      dv_q    <= 1'b0;
      gap_q   <= '0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      gap_q   <= gap_d;
      stray_q <= stray_d;
    end
  end

  exc_result_reg u_result (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .load         (res_load),
    .load_data    (data_q),
    .load_exc     (res_exc),
    .load_timeout (res_timeout),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_exc      (out_exc_e),
    .out_timeout  (out_timeout)
  );

endmodule
